rotate_sequencer: RTL and testbench

//   Controller for the 8-bit rotating shift register datapath.
//   - Builds the load word by concatenation {i_HI, i_LO}.
//   - Sequences a programmed number of single-bit rotations.
//   - Reports progress through a start/busy/done handshake.

---
 rtl/rotate_sequencer.sv | 169 ++++++++++++++++
 tb/tb_rotate_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
// -----------------------------------------------------------------------------
// rotate_sequencer
//
// Controller for an 8-bit (WIDTH-bit) rotating shift register.
//
// On an accepted start it loads the word {i_HI, i_LO} and then performs
// i_STEPS single-bit rotations, one per unstalled cycle. Progress is reported
// through a ready/busy/done handshake.
//
// Optional feature (compile-time macro ROTATE_DIR_EN):
//   - defined   : i_DIR is captured together with i_START and held for the
//                 whole operation (1 = rotate right, 0 = rotate left).
//   - undefined : the block always rotates left. i_DIR is accepted but
//                 ignored, and no direction register is built.
//
// Ports
//   i_CLOCK  in   1        clock; all state updates on its rising edge
//   i_RESET  in   1        synchronous, active-high reset (aborts any operation)
//   i_START  in   1        start request, only honoured while idle
//   i_HI     in   WIDTH/2  upper half of the load word
//   i_LO     in   WIDTH/2  lower half of the load word
//   i_STEPS  in   CNT_W    number of rotations (0 is legal)
//   i_DIR    in   1        rotation direction (see ROTATE_DIR_EN above)
//   i_STALL  in   1        freeze rotation and count for this cycle
//   o_READY  out  1        high while idle
//   o_BUSY   out  1        high while rotating
//   o_DONE   out  1        single-cycle completion pulse
//   o_DATA   out  WIDTH    current register contents
// -----------------------------------------------------------------------------
module rotate_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               i_CLOCK,
    input  logic               i_RESET,
    input  logic               i_START,
    input  logic [WIDTH/2-1:0] i_HI,
    input  logic [WIDTH/2-1:0] i_LO,
    input  logic [CNT_W-1:0]   i_STEPS,
    input  logic               i_DIR,
    input  logic               i_STALL,
    output logic               o_READY,
    output logic               o_BUSY,
    output logic               o_DONE,
    output logic [WIDTH-1:0]   o_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rot_right_s;
    logic [WIDTH-1:0]   rot_left_s;
    logic [WIDTH-1:0]   rot_right_word_s;

`ifdef ROTATE_DIR_EN
    logic               dir_q, dir_d;

    // Direction comes from the value captured at start time.
    always_comb begin
        rot_right_s = dir_q;
    end
`else
    // Name contains "unused": i_DIR is deliberately ignored in this build.
    logic               dir_unused_s;

    // Fixed left rotation; i_DIR is tied off into a sink.
    always_comb begin
        rot_right_s  = 1'b0;
        dir_unused_s = i_DIR;
    end
`endif

    // Both one-bit rotations of the current word.
    always_comb begin
        rot_left_s       = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        rot_right_word_s = {data_q[0], data_q[WIDTH-1:1]};
    end

    // Next-state, next-data and next-count logic.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef ROTATE_DIR_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_START) begin
                    data_d  = {i_HI, i_LO};
                    count_d = i_STEPS;
`ifdef ROTATE_DIR_EN
                    dir_d   = i_DIR;
`endif
                    // A zero-step request completes without ever rotating.
                    if (i_STEPS != CNT_ZERO) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!i_STALL) begin
                    if (rot_right_s) begin
                        data_d = rot_right_word_s;
                    end else begin
                        data_d = rot_left_s;
                    end
                    count_d = count_q - CNT_ONE;
                    // The rotation consuming the last step ends the operation.
                    if (count_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, data and count registers with synchronous reset.
    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            state_q <= ST_IDLE;
            data_q  <= DATA_ZERO;
            count_q <= CNT_ZERO;
`ifdef ROTATE_DIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef ROTATE_DIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Handshake flags are pure decodes of the state register.
    always_comb begin
        o_READY = (state_q == ST_IDLE);
        o_BUSY  = (state_q == ST_SHIFT);
        o_DONE  = (state_q == ST_DONE);
        o_DATA  = data_q;
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rotate_sequencer
//
// Scoreboard bench for rotate_sequencer. The driver issues commands (directed
// cases first, then randomized ones with random stalls and stray start pulses),
// computes the expected final word and completion cycle from a rotate-by-
// (steps mod WIDTH) model, and pushes them into a queue. An independent monitor
// pops one entry per o_DONE pulse and compares.
// -----------------------------------------------------------------------------
module tb_rotate_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       hi;
    logic [3:0]       lo;
    logic [3:0]       steps;
    logic             dir;
    logic             stall;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [7:0]       o_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] last_data;
    bit         prev_done = 1'b0;

    rotate_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_CLOCK (clk),
        .i_RESET (rst),
        .i_START (start),
        .i_HI    (hi),
        .i_LO    (lo),
        .i_STEPS (steps),
        .i_DIR   (dir),
        .i_STALL (stall),
        .o_READY (o_ready),
        .o_BUSY  (o_busy),
        .o_DONE  (o_done),
        .o_DATA  (o_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: rotation by n positions is rotation by n mod WIDTH.
    function automatic logic [7:0] model_rot(input logic [7:0] d, input int n, input logic right);
        logic [15:0] t;
        int r;
        r = n % WIDTH;
        t = {d, d};
`ifdef ROTATE_DIR_EN
        if (right) begin
            t = t >> r;
            return t[7:0];
        end
`else
        if (right) r = r + 0;
`endif
        t = t << r;
        return t[15:8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (o_ready !== 1'b1 && waited < 100) begin
            slot();
            waited++;
        end
        check("ready_before_start", {31'd0, o_ready}, 32'd1);
    endtask

    // One command. rnd=1 picks random stalls, otherwise mask bit j-1 stalls cycle j.
    task automatic do_op(input logic [3:0] h, input logic [3:0] l, input int n,
                         input logic d, input bit rnd, input logic [31:0] mask);
        bit   stall_v[$];
        int   zeros = 0;
        int   lat;
        bit   b;
        logic [7:0] expd;
        exp_t e;
        wait_ready();
        check("data_hold_idle", {24'd0, o_data}, {24'd0, last_data});
        while (zeros < n) begin
            if (rnd) b = ($urandom_range(0, 3) == 0);
            else     b = (stall_v.size() < 32) ? mask[stall_v.size()] : 1'b0;
            stall_v.push_back(b);
            if (!b) zeros++;
        end
        lat  = stall_v.size();
        expd = model_rot({h, l}, n, d);
        hi    = h;
        lo    = l;
        steps = n[3:0];
        dir   = d;
        start = 1'b1;
        stall = 1'($urandom_range(0, 1));
        e.data  = expd;
        e.cycle = cyc + 1 + lat;
        sb_q.push_back(e);
        last_data = expd;
        for (int j = 1; j <= lat + 1; j++) begin
            slot();
            if (j <= lat) check("busy_in_shift", {31'd0, o_busy}, 32'd1);
            start = ($urandom_range(0, 3) == 0);
            hi    = 4'($urandom);
            lo    = 4'($urandom);
            steps = 4'($urandom);
            dir   = 1'($urandom);
            stall = (j <= lat) ? stall_v[j-1] : 1'($urandom_range(0, 1));
        end
        slot();
        start = 1'b0;
        stall = 1'b0;
    endtask

    // Reset in the middle of a rotation: outputs return to idle, no done pulse.
    task automatic do_abort();
        wait_ready();
        hi = 4'hA; lo = 4'h5; steps = 4'd9; dir = 1'b0; start = 1'b1; stall = 1'b0;
        slot();
        start = 1'b0;
        slot();
        check("abort_busy", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        slot();
        rst = 1'b0;
        check("abort_data", {24'd0, o_data}, 32'd0);
        check("abort_flags", {29'd0, o_ready, o_busy, o_done}, 32'd4);
        last_data = 8'h00;
    endtask

    // Monitor: every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (o_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with data %0h expected no done (t=%0t)", o_data, $time);
            end else begin
                e = sb_q.pop_front();
                check("done_data", {24'd0, o_data}, {24'd0, e.data});
                check("done_cycle", cyc, e.cycle);
            end
        end
        if (prev_done) check("ready_after_done", {30'd0, o_ready, o_done}, 32'd2);
        if (!rst) check("flags_onehot", {29'd0, o_ready, o_busy, o_done},
                        (o_ready === 1'b1) ? 32'd4 : ((o_busy === 1'b1) ? 32'd2 : 32'd1));
        prev_done = (o_done === 1'b1);
    end

    initial begin
        int w;
        logic dr;
        rst = 1'b1; start = 1'b0; hi = 4'h0; lo = 4'h0; steps = 4'd0; dir = 1'b0; stall = 1'b0;
        last_data = 8'h00;
        repeat (3) slot();
        check("reset_data", {24'd0, o_data}, 32'd0);
        check("reset_flags", {29'd0, o_ready, o_busy, o_done}, 32'd4);
        rst = 1'b0;
        slot();

        do_op(4'b0111, 4'b1100, 0, 1'b0, 1'b0, 32'h0);
        do_op(4'h0, 4'h1, 3, 1'b0, 1'b0, 32'h0);
        do_op(4'h7, 4'hC, 8, 1'b0, 1'b0, 32'h0);
        do_op(4'h0, 4'h1, 2, 1'b0, 1'b0, 32'h6);
        do_op(4'h0, 4'h1, 1, 1'b1, 1'b0, 32'h0);
        do_op(4'hF, 4'h0, 15, 1'b1, 1'b1, 32'h0);
        do_abort();
        do_op(4'h8, 4'h1, 5, 1'b0, 1'b1, 32'h0);

        for (int i = 0; i < 40; i++) begin
            dr = 1'($urandom);
            do_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 15)), dr, 1'b1, 32'h0);
        end

        w = 0;
        while (sb_q.size() > 0 && w < 200) begin
            slot();
            w++;
        end
        check("scoreboard_drained", sb_q.size(), 32'd0);
        repeat (2) slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
